// File: rtl/nibble_seq_if.sv
// Command/beat bus between the requester, nibble_seq_ctrl and the selector4 select inputs.
// The master side issues commands and sinks beats; the slave side is the sequencer.
interface nibble_seq_if #(
    parameter int PASS_W = 3
);
    logic              START;
    logic [1:0]        MODE;
    logic [PASS_W-1:0] PASSES;
    logic              OUT_READY;
    logic [11:0]       sel_A;
    logic [11:0]       sel_B;
    logic [3:0]        SEL;
    logic              SEL_VALID;
    logic [1:0]        BEAT;
    logic              LAST;
    logic              BUSY;
    logic              DONE;
    logic              ERR;

    modport master (
        output START, MODE, PASSES, OUT_READY,
        input  sel_A, sel_B, SEL, SEL_VALID, BEAT, LAST, BUSY, DONE, ERR
    );

    modport slave (
        input  START, MODE, PASSES, OUT_READY,
        output sel_A, sel_B, SEL, SEL_VALID, BEAT, LAST, BUSY, DONE, ERR
    );
endinterface

// File: rtl/nibble_seq_ctrl.sv
// Sequencer driving selector4 selects so {DATA_B, DATA_A} streams out as four
// 16-bit beats per pass, in LINEAR, INTERLEAVE or REVERSE nibble order.
module nibble_seq_ctrl #(
    parameter int PASS_W = 3
) (
    input logic         CLK,
    input logic         RESET_L,
    nibble_seq_if.slave bus
);
    localparam logic [1:0] MODE_LINEAR     = 2'd0;
    localparam logic [1:0] MODE_INTERLEAVE = 2'd1;
    localparam logic [1:0] MODE_REVERSE    = 2'd2;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] b;
        logic [3:0]  s;
    } sel_t;

    state_t            state;
    logic [1:0]        mode_q;
    logic [PASS_W-1:0] passes_q;
    logic [PASS_W-1:0] pass_q;

    // n is the nibble index into {B,A}; n[3] picks the source word, n[2:0] the nibble.
    function automatic sel_t beat_sel(input logic [1:0] m, input logic [1:0] k);
        sel_t       r;
        logic [3:0] n;
        logic [1:0] slot;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            slot = 2'(i);
            case (m)
                MODE_INTERLEAVE: n = {slot[0], k, slot[1]};
                MODE_REVERSE:    n = ~{k, slot};
                default:         n = {k, slot};
            endcase
            r.s[i] = n[3];
            if (n[3]) r.b[3*i +: 3] = n[2:0];
            else      r.a[3*i +: 3] = n[2:0];
        end
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            state         <= IDLE;
            mode_q        <= '0;
            passes_q      <= '0;
            pass_q        <= '0;
            bus.sel_A     <= '0;
            bus.sel_B     <= '0;
            bus.SEL       <= '0;
            bus.SEL_VALID <= 1'b0;
            bus.BEAT      <= '0;
            bus.LAST      <= 1'b0;
            bus.BUSY      <= 1'b0;
            bus.DONE      <= 1'b0;
            bus.ERR       <= 1'b0;
        end else begin
            bus.DONE <= 1'b0;
            bus.ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        if (bus.MODE != 2'd3 && bus.PASSES != '0) begin
                            state         <= RUN;
                            mode_q        <= bus.MODE;
                            passes_q      <= bus.PASSES;
                            pass_q        <= PASS_W'(1);
                            {bus.sel_A, bus.sel_B, bus.SEL} <= beat_sel(bus.MODE, 2'd0);
                            bus.SEL_VALID <= 1'b1;
                            bus.BEAT      <= 2'd0;
                            bus.LAST      <= 1'b0;
                            bus.BUSY      <= 1'b1;
                        end else begin
                            bus.ERR <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // SEL_VALID is always high in RUN, so OUT_READY alone completes a beat.
                    if (bus.OUT_READY) begin
                        if (bus.BEAT != 2'd3) begin
                            bus.BEAT <= bus.BEAT + 2'd1;
                            {bus.sel_A, bus.sel_B, bus.SEL} <= beat_sel(mode_q, bus.BEAT + 2'd1);
                            bus.LAST <= (bus.BEAT == 2'd2) && (pass_q == passes_q);
                        end else if (pass_q != passes_q) begin
                            pass_q   <= pass_q + PASS_W'(1);
                            bus.BEAT <= 2'd0;
                            {bus.sel_A, bus.sel_B, bus.SEL} <= beat_sel(mode_q, 2'd0);
                            bus.LAST <= 1'b0;
                        end else begin
                            state         <= IDLE;
                            bus.sel_A     <= '0;
                            bus.sel_B     <= '0;
                            bus.SEL       <= '0;
                            bus.SEL_VALID <= 1'b0;
                            bus.BEAT      <= '0;
                            bus.LAST      <= 1'b0;
                            bus.BUSY      <= 1'b0;
                            bus.DONE      <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/nibble_seq_ctrl.md
Name: nibble_seq_ctrl

Overview:
Sequencer that drives the select inputs of the selector4 nibble selector so it streams the 16 nibbles of {DATA_B, DATA_A} as four 16-bit beats.
- A requester issues START with a MODE (ordering) and a pass count.
- The block steps through beats under a valid/ready handshake, then signals DONE.
- It sits between the command source and selector4. It never touches DATA_A/DATA_B.

Parameters:
PASS_W, 3, width of PASSES input and internal pass counter (max passes 2^PASS_W-1).

Ports:
CLK  in  1  clock, rising edge
RESET_L  in  1  synchronous reset, active-low
START  in  1  command strobe, sampled only in IDLE
MODE  in  2  0=LINEAR, 1=INTERLEAVE, 2=REVERSE, 3=reserved
PASSES  in  PASS_W  number of 4-beat passes; 0 is illegal
OUT_READY  in  1  downstream accepts current beat
sel_A  out  12  slot i nibble index from DATA_A at bits [3i+2:3i]
sel_B  out  12  slot i nibble index from DATA_B at bits [3i+2:3i]
SEL  out  4  SEL[i]=1 selects DATA_B for output slot i, 0 selects DATA_A
SEL_VALID  out  1  sel_A/sel_B/SEL hold a valid beat
BEAT  out  2  current beat index 0..3
LAST  out  1  current beat is beat 3 of the final pass
BUSY  out  1  state RUN
DONE  out  1  one-cycle pulse after the final beat handshake
ERR  out  1  one-cycle pulse on rejected START

Behaviour:
- Single clock; reset synchronous, active-low. All outputs are registered.
- Reset values: all outputs 0, state IDLE, latched MODE/PASSES cleared. Reset mid-RUN aborts at the next edge with no DONE.
- States: IDLE, RUN.
- IDLE with START=1:
  - If MODE≠3 and PASSES≠0: latch MODE/PASSES, go to RUN. On the next cycle SEL_VALID=1, BUSY=1, BEAT=0, pass=1, and the beat-0 selection is driven (1-cycle latency).
  - If MODE=3 or PASSES=0: ERR=1 for one cycle, remain IDLE.
- RUN: a beat completes when SEL_VALID & OUT_READY.
  - While OUT_READY=0, all select outputs hold stable.
  - On completion with BEAT<3, BEAT increments.
  - On completion with BEAT=3 and pass<PASSES, BEAT wraps to 0 and pass increments.
  - On completion with BEAT=3 and pass=PASSES, go to IDLE: next cycle SEL_VALID=0, BUSY=0, DONE=1, sel_A/sel_B/SEL/BEAT=0.
- START during RUN is ignored (no ERR). START in the DONE cycle (state IDLE) is accepted, giving back-to-back commands with one idle cycle.
- LAST = (BEAT==3) && (pass==PASSES) && SEL_VALID.
- Unused slot fields in sel_A/sel_B are driven 0.
- Beat k, slot i, with n = nibble index into {B,A} (0..7 = A, 8..15 = B):
  - LINEAR: n = 4k+i.
  - INTERLEAVE: slot0 = A[2k], slot1 = B[2k], slot2 = A[2k+1], slot3 = B[2k+1]; SEL = 1010.
  - REVERSE: n = 15-(4k+i).
- Selections depend only on latched MODE and BEAT; pass does not change them.

Test Plan:
- LINEAR, PASSES=1, OUT_READY=1: START → next cycle beat0 SEL=0000 sel_A=688 sel_B=000; beat1 sel_A=FAC; beat2 SEL=1111 sel_A=000 sel_B=688; beat3 sel_B=FAC with LAST=1; following cycle DONE=1, SEL_VALID=0.
- INTERLEAVE, PASSES=1: beat0 SEL=1010 sel_A=040 sel_B=200; beat3 sel_A=1C6 sel_B=E30.
- REVERSE, PASSES=2, OUT_READY low on cycles 2-3:
  - beat0 SEL=1111 sel_B=977; beat1 sel_B=053 held for 3 cycles; beat2 SEL=0000 sel_A=977; beat3 sel_A=053.
  - Second pass repeats the same beats; LAST only on beat 3 of pass 2; DONE after 8 handshakes.
- START with MODE=3, and START with PASSES=0 → ERR=1 for one cycle, BUSY stays 0, no SEL_VALID.
- START asserted mid-RUN → ignored. START asserted in the DONE cycle → new run begins, SEL_VALID=1 on the next cycle.
- RESET_L=0 at beat 2 → next edge all outputs 0, no DONE. START after release → run restarts at BEAT=0.
